// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between a core port (A)
// and a debug/loader port (B), with bounded burst locking and address checking.
module data_mem_arbiter #(
  parameter int W        = 32,
  parameter int N        = 5,
  parameter int LOCK_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         a_we,
  input  logic         a_lock,
  input  logic [W-1:0] a_addr,
  input  logic [W-1:0] a_wdata,
  output logic         a_gnt,
  output logic         a_done,
  output logic         a_err,
  output logic [W-1:0] a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic         b_lock,
  input  logic [W-1:0] b_addr,
  input  logic [W-1:0] b_wdata,
  output logic         b_gnt,
  output logic         b_done,
  output logic         b_err,
  output logic [W-1:0] b_rdata,
  output logic [W-1:0] mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;

  state_t        state_reg, state_next;
  logic          ptr_reg, ptr_next;   // index of the port served last (0 = A, 1 = B)
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [1:0]    req, we, lock, legal;
  logic [1:0]    gnt_next, gnt, acc, done_v, err_v;
  logic [W-1:0]  addr [2];
  logic [W-1:0]  wdata [2];
  logic [W-1:0]  rdata_v [2];
  logic          hold_side, win, do_arb, sel;

  assign req      = {b_req, a_req};
  assign we       = {b_we, a_we};
  assign lock     = {b_lock, a_lock};
  assign addr[0]  = a_addr;
  assign addr[1]  = b_addr;
  assign wdata[0] = a_wdata;
  assign wdata[1] = b_wdata;

  // Grant and next-state decision; grants are combinational from req and state.
  always_comb begin
    gnt_next   = 2'b00;
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    hold_side  = (state_reg == LOCK_B);
    win        = 1'b0;
    do_arb     = 1'b0;
    case (state_reg)
      LOCK_A, LOCK_B: begin
        if (!req[hold_side]) begin
          do_arb = 1'b1;
        end else if (!req[~hold_side] || cnt_reg < LOCK_MAX_C) begin
          gnt_next[hold_side] = 1'b1;
          ptr_next            = hold_side;
          if (req[~hold_side]) cnt_next = cnt_reg + 1'b1;
          if (!lock[hold_side]) begin
            state_next = ARB;
            cnt_next   = '0;
          end
        end else begin
          gnt_next[~hold_side] = 1'b1;
          ptr_next             = ~hold_side;
          state_next           = ARB;
          cnt_next             = '0;
        end
      end
      default: do_arb = 1'b1;
    endcase
    if (do_arb) begin
      state_next = ARB;
      cnt_next   = '0;
      if (req != 2'b00) begin
        win           = (req == 2'b10) || (req == 2'b11 && !ptr_reg);
        gnt_next[win] = 1'b1;
        ptr_next      = win;
        if (lock[win]) begin
          state_next = win ? LOCK_B : LOCK_A;
          cnt_next   = CW'(1);
        end
      end
    end
  end

  assign gnt = gnt_next & {2{rst}};
  assign acc = req & gnt;
  assign sel = acc[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB;
      ptr_reg   <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Memory pins are only driven in an accept cycle; illegal addresses raise no strobe.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (acc != 2'b00) begin
      mem_address = addr[sel];
      mem_wdata   = wdata[sel];
      mem_write   = we[sel] & legal[sel];
      mem_read    = ~we[sel] & legal[sel];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic         done_reg;
      logic         err_reg;
      logic [W-1:0] rdata_reg;

      assign legal[gi] = (addr[gi][1:0] == 2'b00) && (addr[gi][W-1:N+2] == '0);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          done_reg <= acc[gi];
          err_reg  <= acc[gi] & ~legal[gi];
          if (acc[gi]) rdata_reg <= (legal[gi] && !we[gi]) ? mem_rdata : '0;
        end
      end

      assign done_v[gi]  = done_reg;
      assign err_v[gi]   = err_reg;
      assign rdata_v[gi] = rdata_reg;
    end
  endgenerate

  assign a_gnt   = gnt[0];
  assign b_gnt   = gnt[1];
  assign a_done  = done_v[0];
  assign b_done  = done_v[1];
  assign a_err   = err_v[0];
  assign b_err   = err_v[1];
  assign a_rdata = rdata_v[0];
  assign b_rdata = rdata_v[1];

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port A (core load/store unit) and port B (debug/program-loader).
- Arbitrates round-robin, with an optional bounded lock for back-to-back bursts.
- Rejects misaligned or out-of-range word addresses without touching memory.
- Returns read data registered, with a fixed 1-cycle latency.
- Sits between the requesters and the data memory's address/MemRead/MemWrite/write_data/read_data pins.

Parameters:
- W, 32: data and address width.
- N, 5: memory holds 2**N words; valid byte addresses are 0 to 4*(2**N)-4.
- LOCK_MAX, 4: maximum consecutive grants to one locked requester while the other is waiting.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  port A transaction request.
- a_we  in  1  port A write (1) or read (0).
- a_lock  in  1  port A asks to keep the grant after this transaction.
- a_addr  in  W  port A byte address.
- a_wdata  in  W  port A write data.
- a_gnt  out  1  port A transaction accepted this cycle.
- a_done  out  1  port A response pulse.
- a_err  out  1  port A error flag, valid with a_done.
- a_rdata  out  W  port A read data, valid with a_done on reads.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_done, b_err, b_rdata: identical set for port B.
- mem_address  out  W  to the memory's address input.
- mem_read  out  1  to the memory's MemRead.
- mem_write  out  1  to the memory's MemWrite.
- mem_wdata  out  W  to the memory's write_data.
- mem_rdata  in  W  from the memory's read_data (combinational read).

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to ARB, last-served pointer goes to B (so A wins first), lock counter goes to 0.
  - All done/err/rdata outputs go to 0.
  - a_gnt, b_gnt, mem_read and mem_write are forced to 0 combinationally while rst is low.
  - A transaction in flight when reset asserts is dropped; no done pulse follows.
- Acceptance:
  - At most one gnt per cycle.
  - gnt is combinational from req and state.
  - A transaction is accepted when req and gnt are both high in the same cycle.
  - A requester holds req, we, addr and wdata stable until it sees gnt.
- Memory drive in the accept cycle:
  - mem_address = addr, mem_wdata = wdata.
  - mem_write = we and the address is legal; mem_read = !we and the address is legal.
  - In all other cycles mem_address and mem_wdata are 0 and both strobes are 0.
- Address legality:
  - An address is legal when addr[1:0]==0 and addr[W-1:N+2]==0.
  - An illegal address is still granted (consumed), but no strobe is raised.
- Response:
  - Exactly 1 cycle after acceptance the granted port sees done=1 for one cycle.
  - err=1 with done if the address was illegal.
  - rdata = mem_rdata captured at the accept edge for a legal read; otherwise rdata = 0.
  - rdata holds its value until the next done on that port.
- State machine:
  - ARB:
    - Only one requester → grant it.
    - Both requesting → grant the one not served last, then update the pointer.
    - Granted with lock=1 → go to LOCK_A or LOCK_B, counter = 1.
  - LOCK_X:
    - X is requesting and the other is not, or counter < LOCK_MAX → grant X. Counter increments only when the other port is requesting.
    - X granted with lock=0 → return to ARB.
    - X not requesting → return to ARB; the same cycle is arbitrated as in ARB.
    - counter == LOCK_MAX while the other port requests → grant the other port, pointer = other, go to ARB (forced release).
- Simultaneous requests are never both granted.
- Back-to-back accepts on the same port are legal; done pulses then appear on consecutive cycles.

Test Plan:
- Reset, then B writes 0xDEADBEEF to address 0x10 and reads it back → b_done pulses 1 cycle after each gnt, b_rdata = 0xDEADBEEF, b_err = 0.
- A and B both request reads of 0x04 continuously for 6 cycles → grants alternate A,B,A,B,A,B; A is served first after reset; each done arrives 1 cycle after its gnt.
- A reads 0x06 (misaligned), then 0x80 (out of range for N=5) → each is granted, mem_read stays 0, a_done=1 with a_err=1, a_rdata = 0.
- A holds lock=1 with continuous requests while B requests, LOCK_MAX=4 → A granted 4 cycles, then B granted once, then arbitration resumes.
- A and B write different data to 0x08 in the same cycle → only one gnt; memory holds the winner's data; the loser's write lands next cycle and its value remains.
- rst driven low in the cycle after an accepted read, before its done → no done pulse, outputs go to 0 immediately, A is granted first after release.
